// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU.
//   S1 registers the operand/opcode bundle; S2 registers the signed result and
//   its zero flag. Both stages advance under a ready chain, so the pipe keeps
//   one result per cycle and holds every stage stable under backpressure.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, in_ready       input handshake (in_ready is combinational)
//   A, B [WIDTH-1:0]         unsigned operands
//   op_code [2:0]            ADD SUB AND OR XOR SHL SHR CMP
//   out_valid, out_ready     output handshake
//   C [WIDTH+1:0]            two's-complement result
//   zero_flag                C == 0, qualified by out_valid
//   op_count [CNT_W-1:0]     saturating count of consumed results
module alu_pipe #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] C,
   output logic             zero_flag,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned CW = WIDTH + 2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;

   logic             s2_valid;
   logic [CW-1:0]    s2_c;
   logic             s2_zero;
   logic [CNT_W-1:0] cnt;

   logic             s1_adv;
   logic             s2_adv;
   logic             out_xfer;
   logic [CW-1:0]    a_x;
   logic [CW-1:0]    b_x;
   logic [CW-1:0]    res;

   // Ready chain: a stage may load when empty or when its contents move on.
   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign out_xfer = s2_valid && out_ready;

   // Result of the bundle held in S1, computed at full WIDTH+2 precision.
   always_comb begin
      a_x = CW'(s1_a);
      b_x = CW'(s1_b);
      res = '0;
      case (s1_op)
         OP_ADD: res = a_x + b_x;
         OP_SUB: res = a_x - b_x;
         OP_AND: res = a_x & b_x;
         OP_OR:  res = a_x | b_x;
         OP_XOR: res = a_x ^ b_x;
         OP_SHL: res = a_x << 1;
         OP_SHR: res = a_x >> 1;
         OP_CMP: begin
            if (s1_a > s1_b)      res = CW'(1);
            else if (s1_a < s1_b) res = '1;
            else                  res = '0;
         end
      endcase
   end

   // Stage 1: operand capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= A;
            s1_b  <= B;
            s1_op <= op_code;
         end
      end
   end

   // Stage 2: result and flag; held untouched while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_c     <= '0;
         s2_zero  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_c    <= res;
            s2_zero <= (res == '0);
         end
      end
   end

   // Consumed-result counter, saturating at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (out_xfer && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign out_valid = s2_valid;
   assign C         = s2_c;
   assign zero_flag = s2_zero;
   assign op_count  = cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=4, CNT_W=4).
//   The driver pushes the hand-computed result of every accepted bundle into
//   a queue; an independent monitor pops and compares on each output transfer,
//   and tracks op_count, stall stability and reset behaviour every cycle.
module tb_alu_pipe;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 4;
   localparam int          CNT_MAX = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op_code;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH+1:0] C;
   logic             zero_flag;
   logic [CNT_W-1:0] op_count;

   alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op_code(op_code),
      .out_valid(out_valid), .out_ready(out_ready),
      .C(C), .zero_flag(zero_flag), .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] c;
      logic       z;
      int         acc;
      bit         lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   stalls   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Call at a falling edge; holds the bundle until accepted, then drops in_valid.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [5:0] ec, input bit lat);
      int   waited = 0;
      exp_t e;
      in_valid = 1'b1;
      op_code  = op;
      A        = a;
      B        = b;
      #1;
      while (!in_ready && waited <= 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      stalls += waited;
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at 0 for op %0d", op);
      end else begin
         e.c   = ec;
         e.z   = (ec == 6'd0);
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Call at a falling edge; returns at a falling edge after release.
   task automatic do_reset(input int n);
      rst = 1'b1;
      sb.delete();
      repeat (n) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", in_ready, 1);
      @(negedge clk);
   endtask

   // Monitor: checks state each cycle just before the transfer edge.
   initial begin
      bit         prev_stall = 1'b0;
      logic [5:0] prev_c     = '0;
      int         model      = 0;
      exp_t       e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            chk("reset_out_valid", out_valid, 0);
            chk("reset_c", C, 0);
            chk("reset_op_count", op_count, 0);
            model      = 0;
            prev_stall = 1'b0;
         end else begin
            chk("op_count", op_count, model);
            if (prev_stall) begin
               chk("stall_out_valid", out_valid, 1);
               chk("stall_c", C, prev_c);
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got C=%0d expected no output", C);
               end else if (out_ready) begin
                  e = sb.pop_front();
                  chk("result_c", C, e.c);
                  chk("zero_flag", zero_flag, e.z);
                  if (e.lat) chk("latency", cyc - e.acc, 2);
                  if (model != CNT_MAX) model++;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = C;
         end
      end
   end

   // Directed vectors: op, A, B, hand-computed 6-bit two's-complement C.
   logic [2:0] v_op [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd4, 3'd7,
                            3'd3, 3'd5, 3'd6, 3'd7, 3'd7, 3'd1, 3'd0};
   logic [3:0] v_a  [14] = '{4'd1, 4'd15, 4'd14, 4'd15, 4'd15, 4'd5, 4'd1,
                            4'd10, 4'd15, 4'd9, 4'd9, 4'd7, 4'd0, 4'd0};
   logic [3:0] v_b  [14] = '{4'd9, 4'd15, 4'd15, 4'd14, 4'd1, 4'd5, 4'd9,
                            4'd5, 4'd0, 4'd0, 4'd1, 4'd7, 4'd15, 4'd0};
   logic [5:0] v_c  [14] = '{6'd10, 6'd30, 6'h3F, 6'd1, 6'd1, 6'd0, 6'h3F,
                            6'd15, 6'd30, 6'd4, 6'd1, 6'd0, 6'h31, 6'd0};

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      op_code   = '0;
      out_ready = 1'b1;

      // Power-on reset, idle inputs.
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", in_ready, 1);
      chk("out_valid_after_reset", out_valid, 0);
      @(negedge clk);

      // All operations, no backpressure.
      for (int i = 0; i < 14; i++) send(v_op[i], v_a[i], v_b[i], v_c[i], 1'b1);
      repeat (4) @(negedge clk);
      #1;
      chk("directed_drained", sb.size(), 0);
      @(negedge clk);

      // Backpressure: two bundles fill the pipe, third waits.
      do_reset(2);
      out_ready = 1'b0;
      fork
         begin
            send(3'd0, 4'd1, 4'd2, 6'd3, 1'b0);
            send(3'd0, 4'd3, 4'd4, 6'd7, 1'b0);
            send(3'd0, 4'd5, 4'd6, 6'd11, 1'b0);
         end
         begin
            repeat (4) @(negedge clk);
            #1;
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
            chk("full_c", C, 3);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      #1;
      chk("stall_op_count", op_count, 3);
      chk("stall_drained", sb.size(), 0);
      @(negedge clk);

      // Back-to-back stream: one result per cycle.
      do_reset(2);
      stalls = 0;
      for (int i = 0; i < 8; i++)
         send(3'd0, 4'(i), 4'(i + 1), 6'(2 * i + 1), 1'b1);
      chk("b2b_no_input_stall", stalls, 0);
      repeat (4) @(negedge clk);
      #1;
      chk("b2b_op_count", op_count, 8);
      @(negedge clk);

      // Counter saturation.
      for (int i = 0; i < 10; i++)
         send(3'd1, 4'd15, 4'(i), 6'(15 - i), 1'b1);
      repeat (4) @(negedge clk);
      #1;
      chk("sat_op_count", op_count, CNT_MAX);
      @(negedge clk);

      // Reset with two bundles in flight.
      out_ready = 1'b0;
      send(3'd4, 4'd3, 4'd1, 6'd2, 1'b0);
      send(3'd3, 4'd4, 4'd1, 6'd5, 1'b0);
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_c", C, 0);
      chk("midrst_zero_flag", zero_flag, 0);
      chk("midrst_op_count", op_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("midrst_no_stale", out_valid, 0);
      chk("midrst_final_count", op_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (WIDTH >= 2).
REQ-002 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand/opcode bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle this cycle.
REQ-007 A  input  WIDTH  operand A, unsigned.
REQ-008 B  input  WIDTH  operand B, unsigned.
REQ-009 op_code  input  3  operation select.
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 C  output  WIDTH+2  result, two's-complement signed.
REQ-013 zero_flag  output  1  C == 0, valid with out_valid.
REQ-014 op_count  output  CNT_W  number of results consumed since reset.

Function
REQ-015 Two register stages: S1 captures A, B, op_code; S2 holds computed C and zero_flag.
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependency on in_valid).
REQ-018 Latency: bundle accepted at edge N appears on C with out_valid=1 after edge N+2 when no backpressure; throughput one result per cycle.
REQ-019 When S2 is stalled (out_valid && !out_ready), C, zero_flag and out_valid SHALL hold stable; S1 holds if also full.
REQ-020 Results SHALL leave in acceptance order; no bundle dropped or duplicated while rst is low.
REQ-021 Operands zero-extended to WIDTH+2 before computing; no truncation for any op.
REQ-022 op 000 ADD: C = A + B (max 2*(2^WIDTH-1)).
REQ-023 op 001 SUB: C = A - B, negative results in two's complement.
REQ-024 op 010 AND, 011 OR, 100 XOR: bitwise on A,B, zero-extended.
REQ-025 op 101 SHL: C = A << 1; op 110 SHR: C = A >> 1 (logical).
REQ-026 op 111 CMP: C = +1 if A > B, 0 if A == B, -1 if A < B.
REQ-027 zero_flag = (C == 0), registered with C in S2.
REQ-028 op_count increments by 1 on each output transfer; saturates at 2^CNT_W-1 (no wrap).
REQ-029 Simultaneous output transfer and new input acceptance in the same cycle SHALL both complete with no bubble.

Reset
REQ-030 While rst=1: S1/S2 valid bits=0, out_valid=0, C=0, zero_flag=0, op_count=0, asynchronously (no clock edge needed).
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight bundles; none appear after release.

Verification
REQ-033 rst=1 for 5 cycles, in_valid=0 -> C=0, out_valid=0, op_count=0 throughout; in_ready=1 after release.
REQ-034 WIDTH=4, ADD A=1,B=9 -> C=10, zero_flag=0, out_valid 2 cycles after accept; ADD A=15,B=15 -> C=30.
REQ-035 SUB A=14,B=15 -> C=-1 (6'b111111); SUB A=15,B=14 -> C=1; AND A=15,B=1 -> C=1; XOR A=5,B=5 -> C=0, zero_flag=1; CMP A=1,B=9 -> C=-1.
REQ-036 out_ready=0, in_valid=1 with 3 ADD bundles -> first 2 accepted, in_ready=0 on third, C stable; then out_ready=1 -> 3 results in order, op_count=3.
REQ-037 Back-to-back 8 bundles with out_ready=1 -> one result per cycle, no bubbles, op_count=8.
REQ-038 Two bundles in flight, assert rst mid-cycle -> out_valid falls immediately, op_count=0, no stale result after release.
